// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// Valid/ready note: there is no ready; a requester holds req[i] high until it sees itself granted and is done.
interface decoder_rr_arbiter_if #(
  parameter int unsigned CNT_W = 8
);
  logic [7:0]       req;
  logic             gnt_valid;
  logic [2:0]       gnt_idx;
  logic [7:0]       gnt_onehot;
  logic [CNT_W-1:0] hold_cnt;
  logic             preempt;

  modport master (
    output req,
    input  gnt_valid, gnt_idx, gnt_onehot, hold_cnt, preempt
  );

  modport slave (
    input  req,
    output gnt_valid, gnt_idx, gnt_onehot, hold_cnt, preempt
  );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for 8 requesters driving a shared 3:8 decoded select bus.
// Grants are held while requested and pre-empted after MAX_HOLD cycles when others wait.
module decoder_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  decoder_rr_arbiter_if.slave  bus,
  output logic                 dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [7:0]       onehot_q, onehot_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             preempt_q, preempt_d;

  logic [7:0] others;
  logic [2:0] sel_req, sel_oth;
  logic       owner_req, any_req, any_oth;

  // Descending scan so the candidate closest to start is written last and wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] mask, input logic [2:0] start);
    logic [2:0] cand;
    rr_pick = start;
    for (int k = 7; k >= 0; k--) begin
      cand = start + 3'(k);
      if (mask[cand]) rr_pick = cand;
    end
  endfunction

  always_comb begin
    others    = bus.req & ~(8'b1 << idx_q);
    owner_req = bus.req[idx_q];
    any_req   = |bus.req;
    any_oth   = |others;
    sel_req   = rr_pick(bus.req, ptr_q);
    sel_oth   = rr_pick(others, ptr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      idx_q     <= 3'd0;
      valid_q   <= 1'b0;
      onehot_q  <= 8'h00;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      onehot_q  <= onehot_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = GRANT;
      GRANT:   if (!owner_req && !any_oth) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    ptr_d     = ptr_q;
    preempt_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          valid_d = 1'b1;
          idx_d   = sel_req;
          hold_d  = '0;
          ptr_d   = sel_req + 3'd1;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          if (any_oth) begin
            idx_d  = sel_oth;
            hold_d = '0;
            ptr_d  = sel_oth + 3'd1;
          end else begin
            valid_d = 1'b0;
            idx_d   = 3'd0;
            hold_d  = '0;
          end
        end else if (hold_q == HOLD_LAST) begin
          // With nobody waiting the owner keeps the bus and the counter saturates.
          if (any_oth) begin
            idx_d     = sel_oth;
            hold_d    = '0;
            ptr_d     = sel_oth + 3'd1;
            preempt_d = 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: ;
    endcase
    onehot_d = valid_d ? (8'b1 << idx_d) : 8'h00;
  end

  assign bus.gnt_valid  = valid_q;
  assign bus.gnt_idx    = idx_q;
  assign bus.gnt_onehot = onehot_q;
  assign bus.hold_cnt   = hold_q;
  assign bus.preempt    = preempt_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter with MAX_HOLD=4: reset, rotation, wrap, timeout, lone holder, reset mid-grant.
module tb_decoder_rr_arbiter;
  localparam int unsigned MAX_HOLD = 4;
  localparam int unsigned CNT_W    = 8;

  logic clk;
  logic rst;
  logic dbg_state;
  int   tests_run = 0;
  int   tests_failed = 0;

  decoder_rr_arbiter_if #(.CNT_W(CNT_W)) bus_if ();

  decoder_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if.slave),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view {state, valid, idx, onehot, hold, preempt}; state is GRANT exactly when a grant is valid.
  task automatic check(input string tag, input logic valid, input logic [2:0] idx,
                       input int hold, input logic pre);
    logic [21:0] obs, exp;
    logic [7:0]  oh;
    oh  = valid ? (8'b1 << idx) : 8'h00;
    exp = {valid, valid, idx, oh, CNT_W'(hold), pre};
    obs = {dbg_state, bus_if.gnt_valid, bus_if.gnt_idx, bus_if.gnt_onehot,
           bus_if.hold_cnt, bus_if.preempt};
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int o, other;
    rst = 1'b1;
    bus_if.req = 8'hFF;

    // Reset dominates a full request vector.
    tick();
    tick();
    check("reset", 1'b0, 3'd0, 0, 1'b0);
    rst = 1'b0;
    tick();
    check("post_reset_grant0", 1'b1, 3'd0, 0, 1'b0);
    bus_if.req = 8'h00;
    tick();
    check("release_to_idle", 1'b0, 3'd0, 0, 1'b0);

    // Rotation between 2 and 5 with no idle cycle (ptr=1 here).
    bus_if.req = 8'b0010_0100;
    tick();
    check("rot_first", 1'b1, 3'd2, 0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      o     = (r % 2 == 0) ? 2 : 5;
      other = (r % 2 == 0) ? 5 : 2;
      bus_if.req = 8'b0010_0100;
      tick();
      check("rot_hold1", 1'b1, 3'(o), 1, 1'b0);
      tick();
      check("rot_hold2", 1'b1, 3'(o), 2, 1'b0);
      bus_if.req = 8'b1 << other;
      tick();
      check("rot_switch", 1'b1, 3'(other), 0, 1'b0);
    end

    // Wrap: owner 2 (ptr=3) hands to 7, ptr wraps to 0.
    bus_if.req = 8'b1000_0000;
    tick();
    check("wrap_owner7", 1'b1, 3'd7, 0, 1'b0);
    bus_if.req = 8'h00;
    tick();
    check("wrap_idle", 1'b0, 3'd0, 0, 1'b0);
    bus_if.req = 8'b1000_0001;
    tick();
    check("wrap_owner0", 1'b1, 3'd0, 0, 1'b0);
    bus_if.req = 8'h00;
    tick();
    check("wrap_idle2", 1'b0, 3'd0, 0, 1'b0);

    // Timeout: ptr=1, owner 3, 6 joins one cycle later.
    bus_if.req = 8'b0000_1000;
    tick();
    check("to_owner3_h0", 1'b1, 3'd3, 0, 1'b0);
    bus_if.req = 8'b0100_1000;
    tick();
    check("to_owner3_h1", 1'b1, 3'd3, 1, 1'b0);
    tick();
    check("to_owner3_h2", 1'b1, 3'd3, 2, 1'b0);
    tick();
    check("to_owner3_h3", 1'b1, 3'd3, 3, 1'b0);
    tick();
    check("to_preempt6", 1'b1, 3'd6, 0, 1'b1);
    tick();
    check("to_owner6_h1", 1'b1, 3'd6, 1, 1'b0);
    tick();
    check("to_owner6_h2", 1'b1, 3'd6, 2, 1'b0);
    tick();
    check("to_owner6_h3", 1'b1, 3'd6, 3, 1'b0);
    tick();
    check("to_preempt3", 1'b1, 3'd3, 0, 1'b1);
    bus_if.req = 8'h00;
    tick();
    check("to_idle", 1'b0, 3'd0, 0, 1'b0);

    // Lone holder: ptr=4, only requester 1, counter saturates at MAX_HOLD-1.
    bus_if.req = 8'b0000_0010;
    for (int k = 0; k < 40; k++) begin
      tick();
      check("lone", 1'b1, 3'd1, (k < MAX_HOLD - 1) ? k : MAX_HOLD - 1, 1'b0);
    end
    bus_if.req = 8'h00;
    tick();
    check("lone_idle", 1'b0, 3'd0, 0, 1'b0);

    // Reset in the middle of a grant to 4.
    bus_if.req = 8'h10;
    tick();
    check("mid_owner4_h0", 1'b1, 3'd4, 0, 1'b0);
    tick();
    tick();
    check("mid_owner4_h2", 1'b1, 3'd4, 2, 1'b0);
    rst = 1'b1;
    tick();
    check("mid_reset", 1'b0, 3'd0, 0, 1'b0);
    rst = 1'b0;
    tick();
    check("mid_regrant4", 1'b1, 3'd4, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
